mips_multicycle_ctrl: RTL and testbench

- Sequential main controller for the multi-cycle variant of the MIPS core.
- Consumes opcode, funct and the ALU zero flag from the datapath. Produces every datapath enable and select signal, one FSM state per cycle.
- Replaces the combinational single-cycle decoder.
- Stalls on a memory ready handshake so instruction and data can share a single memory.

---
 rtl/mips_multicycle_ctrl_if.sv | 39 +++
 rtl/mips_multicycle_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bundle for the multi-cycle MIPS core.
// The controller (master) consumes instruction fields, the zero flag and the
// memory ready handshake, and drives every datapath enable/select.
interface mips_multicycle_ctrl_if #(parameter int ST_W = 4);
    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic            zero;
    logic            mem_ready;
    logic            IorD;
    logic            MemWrite;
    logic            IRWrite;
    logic            PCWrite;
    logic            Branch;
    logic            PCEn;
    logic [1:0]      PCSrc;
    logic            ALUSrcA;
    logic [1:0]      ALUSrcB;
    logic [2:0]      ALU_control;
    logic            RegDst;
    logic            MemtoReg;
    logic            RegWrite;
    logic            instr_retired;
    logic            illegal_op;
    logic [ST_W-1:0] state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output IorD, MemWrite, IRWrite, PCWrite, Branch, PCEn, PCSrc,
               ALUSrcA, ALUSrcB, ALU_control, RegDst, MemtoReg, RegWrite,
               instr_retired, illegal_op, state
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  IorD, MemWrite, IRWrite, PCWrite, Branch, PCEn, PCSrc,
               ALUSrcA, ALUSrcB, ALU_control, RegDst, MemtoReg, RegWrite,
               instr_retired, illegal_op, state
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main controller: Moore FSM, one state per cycle, stalling
// on mem_ready so instruction fetch and data access can share one memory.
module mips_multicycle_ctrl #(
    parameter int ST_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    mips_multicycle_ctrl_if.master bus
);
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [ST_W-1:0] {
        S_IDLE    = ST_W'(0),
        S_FETCH   = ST_W'(1),
        S_DECODE  = ST_W'(2),
        S_MEMADR  = ST_W'(3),
        S_MEMRD   = ST_W'(4),
        S_MEMWB   = ST_W'(5),
        S_MEMWR   = ST_W'(6),
        S_EXECUTE = ST_W'(7),
        S_ALUWB   = ST_W'(8),
        S_BRANCH  = ST_W'(9),
        S_ADDIEX  = ST_W'(10),
        S_ADDIWB  = ST_W'(11),
        S_JUMP    = ST_W'(12)
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] funct_alu;
    logic       funct_ok;
    logic       pc_write;
    logic       branch;

    // R-type funct to ALU operation; funct_ok flags the supported subset.
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = 3'b010;
        case (bus.funct)
            6'b100000: funct_alu = 3'b010;
            6'b100010: funct_alu = 3'b110;
            6'b100100: funct_alu = 3'b000;
            6'b100101: funct_alu = 3'b001;
            6'b101010: funct_alu = 3'b111;
            default:   funct_ok  = 1'b0;
        endcase
    end

    // Next-state selection; opcode/funct are only consulted from DECODE on.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = funct_ok ? S_EXECUTE : S_FETCH;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // State register; reset wins over any state, including a memory stall.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Output decode from the current state (plus the few documented inputs).
    always_comb begin
        bus.IorD          = 1'b0;
        bus.MemWrite      = 1'b0;
        bus.IRWrite       = 1'b0;
        pc_write          = 1'b0;
        branch            = 1'b0;
        bus.PCSrc         = 2'b00;
        bus.ALUSrcA       = 1'b0;
        bus.ALUSrcB       = 2'b00;
        bus.ALU_control   = 3'b000;
        bus.RegDst        = 1'b0;
        bus.MemtoReg      = 1'b0;
        bus.RegWrite      = 1'b0;
        bus.instr_retired = 1'b0;
        bus.illegal_op    = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.ALUSrcB     = 2'b01;
                bus.ALU_control = 3'b010;
                bus.IRWrite     = bus.mem_ready;
                pc_write        = bus.mem_ready;
            end
            S_DECODE: begin
                // ALU precomputes the branch target while the opcode decodes.
                bus.ALUSrcB     = 2'b11;
                bus.ALU_control = 3'b010;
                bus.illegal_op  = (state_d == S_FETCH);
            end
            S_MEMADR, S_ADDIEX: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUSrcB     = 2'b10;
                bus.ALU_control = 3'b010;
            end
            S_MEMRD: bus.IorD = 1'b1;
            S_MEMWB: begin
                bus.MemtoReg      = 1'b1;
                bus.RegWrite      = 1'b1;
                bus.instr_retired = 1'b1;
            end
            S_MEMWR: begin
                // Strobe held steady for the whole stall; retire on completion.
                bus.IorD          = 1'b1;
                bus.MemWrite      = 1'b1;
                bus.instr_retired = bus.mem_ready;
            end
            S_EXECUTE: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALU_control = funct_alu;
            end
            S_ALUWB: begin
                bus.RegDst        = 1'b1;
                bus.RegWrite      = 1'b1;
                bus.instr_retired = 1'b1;
            end
            S_BRANCH: begin
                bus.ALUSrcA       = 1'b1;
                bus.ALU_control   = 3'b110;
                branch            = 1'b1;
                bus.PCSrc         = 2'b01;
                bus.instr_retired = 1'b1;
            end
            S_ADDIWB: begin
                bus.RegWrite      = 1'b1;
                bus.instr_retired = 1'b1;
            end
            S_JUMP: begin
                bus.PCSrc         = 2'b10;
                pc_write          = 1'b1;
                bus.instr_retired = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.PCWrite = pc_write;
    assign bus.Branch  = branch;
    assign bus.PCEn    = pc_write | (branch & bus.zero);
    assign bus.state   = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed scenarios plus random instruction
// streams, each cycle checked against a phase-table reference model.
module tb_mips_multicycle_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips_multicycle_ctrl_if #(.ST_W(4)) bus();
    mips_multicycle_ctrl #(.ST_W(4)) dut (.clk(clk), .reset(reset), .bus(bus.master));

    // Abstract instruction phases; the numeric state code is learnt, not assumed.
    typedef enum int {P_IDLE, P_F, P_D, P_MA, P_MR, P_MWB, P_MW,
                      P_EX, P_AWB, P_BR, P_AX, P_IWB, P_J} ph_t;

    int n_cmp = 0;
    int n_err = 0;
    int code [13];

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit legal(logic [5:0] op, logic [5:0] fn);
        if (op == 6'b000000)
            return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        return op inside {6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    endfunction

    function automatic logic [2:0] alu_of(logic [5:0] fn);
        case (fn)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected control word for one cycle of a given phase.
    function automatic logic [18:0] expw(ph_t p, logic [5:0] op, logic [5:0] fn,
                                         logic mr, logic z);
        logic iord = 0, mw = 0, irw = 0, pcw = 0, br = 0, sa = 0;
        logic rd = 0, m2r = 0, rw = 0, ret = 0, ill = 0;
        logic [1:0] psrc = 0, sb = 0;
        logic [2:0] alu = 0;
        case (p)
            P_F:   begin sb = 2'b01; alu = 3'b010; irw = mr; pcw = mr; end
            P_D:   begin sb = 2'b11; alu = 3'b010; ill = !legal(op, fn); end
            P_MA:  begin sa = 1; sb = 2'b10; alu = 3'b010; end
            P_MR:  iord = 1;
            P_MWB: begin m2r = 1; rw = 1; ret = 1; end
            P_MW:  begin iord = 1; mw = 1; ret = mr; end
            P_EX:  begin sa = 1; alu = alu_of(fn); end
            P_AWB: begin rd = 1; rw = 1; ret = 1; end
            P_BR:  begin sa = 1; alu = 3'b110; br = 1; psrc = 2'b01; ret = 1; end
            P_AX:  begin sa = 1; sb = 2'b10; alu = 3'b010; end
            P_IWB: begin rw = 1; ret = 1; end
            P_J:   begin psrc = 2'b10; pcw = 1; ret = 1; end
            default: ;
        endcase
        return {iord, mw, irw, pcw, br, pcw | (br & z), psrc, sa, sb, alu,
                rd, m2r, rw, ret, ill};
    endfunction

    function automatic logic [18:0] obsw();
        return {bus.IorD, bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.Branch,
                bus.PCEn, bus.PCSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALU_control,
                bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.instr_retired,
                bus.illegal_op};
    endfunction

    task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance.
    task automatic step(ph_t p, logic mr, logic z);
        int dup;
        bus.mem_ready = mr;
        bus.zero      = z;
        #4;
        chk($sformatf("ctl ph=%0d op=%b fn=%b mr=%b z=%b", p, bus.opcode,
                      bus.funct, mr, z), 32'(obsw()),
            32'(expw(p, bus.opcode, bus.funct, mr, z)));
        if (p == P_IDLE) begin
            chk("state_idle", 32'(bus.state), 32'd0);
        end else if (code[p] < 0) begin
            dup = 0;
            for (int q = 0; q < 13; q++) if (code[q] == int'(bus.state)) dup = 1;
            chk($sformatf("state_new ph=%0d", p), 32'(dup), 32'd0);
            code[p] = int'(bus.state);
        end else begin
            chk($sformatf("state_code ph=%0d", p), 32'(bus.state), 32'(code[p]));
        end
        @(posedge clk);
        #1;
    endtask

    // Run one instruction from FETCH to retire, with the given stall counts.
    task automatic run_instr(logic [5:0] op, logic [5:0] fn, logic z,
                             int fst, int mst);
        bus.opcode = op;
        bus.funct  = fn;
        for (int k = 0; k <= fst; k++) step(P_F, k == fst, rb());
        step(P_D, rb(), rb());
        if (!legal(op, fn)) return;
        case (op)
            6'b100011: begin
                step(P_MA, rb(), rb());
                for (int k = 0; k <= mst; k++) step(P_MR, k == mst, rb());
                step(P_MWB, rb(), rb());
            end
            6'b101011: begin
                step(P_MA, rb(), rb());
                for (int k = 0; k <= mst; k++) step(P_MW, k == mst, rb());
            end
            6'b000000: begin step(P_EX, rb(), rb()); step(P_AWB, rb(), rb()); end
            6'b000100: step(P_BR, rb(), z);
            6'b001000: begin step(P_AX, rb(), rb()); step(P_IWB, rb(), rb()); end
            default:   step(P_J, rb(), rb());
        endcase
    endtask

    logic [5:0] op_r, fn_r;
    int sel;

    initial begin
        for (int i = 0; i < 13; i++) code[i] = -1;
        reset = 1'b1;
        bus.opcode = 6'b0; bus.funct = 6'b0; bus.zero = 1'b0; bus.mem_ready = 1'b1;

        // Reset held two edges, then released: IDLE, then FETCH.
        @(posedge clk); #1;
        step(P_IDLE, 1'b1, 1'b1);
        reset = 1'b0;
        step(P_IDLE, 1'b1, 1'b1);

        // Directed scenarios.
        run_instr(6'b000000, 6'b100010, 1'b0, 0, 0);  // R-type sub
        run_instr(6'b100011, 6'b000000, 1'b0, 3, 2);  // lw with stalls
        run_instr(6'b101011, 6'b000000, 1'b0, 0, 1);  // sw, one-cycle stall
        run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);  // beq taken
        run_instr(6'b000100, 6'b000000, 1'b0, 0, 0);  // beq not taken
        run_instr(6'b000010, 6'b000000, 1'b0, 0, 0);  // j
        run_instr(6'b001000, 6'b000000, 1'b0, 0, 0);  // addi
        run_instr(6'b111111, 6'b000000, 1'b0, 0, 0);  // illegal opcode
        run_instr(6'b000000, 6'b000111, 1'b0, 0, 0);  // illegal funct

        // Reset during an sw memory stall.
        bus.opcode = 6'b101011;
        step(P_F, 1'b1, 1'b0);
        step(P_D, 1'b1, 1'b0);
        step(P_MA, 1'b0, 1'b0);
        bus.mem_ready = 1'b0;
        #4;
        chk("sw_stall_memwrite", 32'(bus.MemWrite), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        step(P_IDLE, 1'b0, 1'b1);
        run_instr(6'b000000, 6'b100000, 1'b0, 0, 0);

        // Random instruction stream.
        for (int n = 0; n < 60; n++) begin
            sel  = $urandom_range(0, 7);
            fn_r = 6'($urandom);
            case (sel)
                0: begin
                    op_r = 6'b000000;
                    if ($urandom_range(0, 3) != 0)
                        case ($urandom_range(0, 4))
                            0: fn_r = 6'b100000;
                            1: fn_r = 6'b100010;
                            2: fn_r = 6'b100100;
                            3: fn_r = 6'b100101;
                            default: fn_r = 6'b101010;
                        endcase
                end
                1: op_r = 6'b100011;
                2: op_r = 6'b101011;
                3: op_r = 6'b000100;
                4: op_r = 6'b001000;
                5: op_r = 6'b000010;
                default: op_r = 6'($urandom);
            endcase
            run_instr(op_r, fn_r, rb(), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
